// File: rtl/multiboot_ctrl.sv
// multiboot_ctrl: selects the SPI flash bitstream address and issues the
// single-cycle reboot request to the downstream ICAP multiboot sequencer.
//
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   io_wr, io_rd     register write / read strobes (read is informational)
//   io_addr, io_di   register select (0 ADDR_L, 1 ADDR_M, 2 ADDR_H, 3 CTRL)
//                    and write data
//   io_do            read data (combinational)
//   key_boot         recovery key, held HOLD_CYCLES to boot GOLDEN_ADDR
//   spi_addr         registered bitstream address, changes only entering FIRE
//   reboot           registered one-cycle reboot request
//   busy             high during FIRE and HOLDOFF
//
// Build option: MULTIBOOT_READBACK_EN enables register readback on io_do;
// without it io_do is the constant 8'hFF.
module multiboot_ctrl #(
    parameter logic [23:0] GOLDEN_ADDR    = 24'h000000,
    parameter int unsigned HOLD_CYCLES    = 20000000,
    parameter int unsigned HOLDOFF_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [1:0]  io_addr,
    input  logic [7:0]  io_di,
    output logic [7:0]  io_do,
    input  logic        key_boot,
    output logic [23:0] spi_addr,
    output logic        reboot,
    output logic        busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int OW = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);
    localparam logic [OW-1:0] OFF_LAST = OW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_LOCKED,
        S_KEY1,
        S_ARMED,
        S_FIRE,
        S_HOLDOFF
    } state_t;

    state_t        state_q, state_d;
    logic [23:0]   addr_q, addr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [OW-1:0] off_q, off_d;
    logic [23:0]   spi_q, spi_d;
    logic          reboot_q, reboot_d;
    logic          busy_q, busy_d;

    logic idle;
    logic wr_addr;
    logic wr_ctrl;
    logic key_fire;
    logic ctrl_fire;

    assign idle = (state_q == S_LOCKED) ||
                  (state_q == S_KEY1)   ||
                  (state_q == S_ARMED);

    assign wr_addr = io_wr && idle && (io_addr != 2'd3);
    assign wr_ctrl = io_wr && idle && (io_addr == 2'd3);

    // Fire only on the transition into the terminal count, so a key held
    // through HOLDOFF (counter saturated) cannot refire.
    assign key_fire  = key_boot && idle && (hold_q == HOLD_PRE);
    assign ctrl_fire = wr_ctrl && (state_q == S_ARMED) &&
                       (io_di == 8'h01);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        spi_d    = spi_q;
        reboot_d = 1'b0;

        if (!key_boot) begin
            hold_d = '0;
        end else if (hold_q == HOLD_MAX) begin
            hold_d = hold_q;
        end else begin
            hold_d = hold_q + HW'(1);
        end

        if (wr_addr) begin
            case (io_addr)
                2'd0:    addr_d[7:0]   = io_di;
                2'd1:    addr_d[15:8]  = io_di;
                default: addr_d[23:16] = io_di;
            endcase
        end

        case (state_q)
            S_LOCKED: begin
                if (wr_ctrl) begin
                    state_d = (io_di == 8'hA5) ? S_KEY1 : S_LOCKED;
                end
            end
            S_KEY1: begin
                if (wr_ctrl) begin
                    state_d = (io_di == 8'h5A) ? S_ARMED : S_LOCKED;
                end
            end
            S_ARMED: begin
                if (wr_ctrl) begin
                    state_d = S_LOCKED;
                end
            end
            S_FIRE: begin
                state_d = S_HOLDOFF;
                off_d   = '0;
            end
            S_HOLDOFF: begin
                if (off_q == OFF_LAST) begin
                    state_d = S_LOCKED;
                end else begin
                    off_d = off_q + OW'(1);
                end
            end
            default: state_d = S_LOCKED;
        endcase

        // Key path has priority over a simultaneous CTRL trigger.
        if (key_fire || ctrl_fire) begin
            state_d  = S_FIRE;
            reboot_d = 1'b1;
            spi_d    = key_fire ? GOLDEN_ADDR : addr_q;
        end

        busy_d = (state_d == S_FIRE) || (state_d == S_HOLDOFF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_LOCKED;
            addr_q   <= '0;
            hold_q   <= '0;
            off_q    <= '0;
            spi_q    <= GOLDEN_ADDR;
            reboot_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            hold_q   <= hold_d;
            off_q    <= off_d;
            spi_q    <= spi_d;
            reboot_q <= reboot_d;
            busy_q   <= busy_d;
        end
    end

    assign spi_addr = spi_q;
    assign reboot   = reboot_q;
    assign busy     = busy_q;

    logic unused_rd;
    assign unused_rd = io_rd;

`ifdef MULTIBOOT_READBACK_EN
    logic [1:0] st_code;

    always_comb begin
        case (state_q)
            S_LOCKED: st_code = 2'd0;
            S_KEY1:   st_code = 2'd1;
            S_ARMED:  st_code = 2'd2;
            default:  st_code = 2'd3;
        endcase

        case (io_addr)
            2'd0:    io_do = addr_q[7:0];
            2'd1:    io_do = addr_q[15:8];
            2'd2:    io_do = addr_q[23:16];
            default: io_do = {5'b0, busy_q, st_code};
        endcase
    end
`else
    assign io_do = 8'hFF;
`endif

endmodule

// File: tb/tb_multiboot_ctrl.sv
// Self-checking bench for multiboot_ctrl: directed table, corner-case
// sequences and randomized traffic against a behavioural model.
module tb_multiboot_ctrl;

    localparam int HOLD    = 16;
    localparam int HOLDOFF = 8;
    localparam logic [23:0] GOLDEN = 24'h000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_wr = 1'b0;
    logic        io_rd = 1'b0;
    logic [1:0]  io_addr = 2'd0;
    logic [7:0]  io_di = 8'h00;
    logic [7:0]  io_do;
    logic        key_boot = 1'b0;
    logic [23:0] spi_addr;
    logic        reboot;
    logic        busy;

    multiboot_ctrl #(
        .GOLDEN_ADDR    (GOLDEN),
        .HOLD_CYCLES    (HOLD),
        .HOLDOFF_CYCLES (HOLDOFF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .io_wr    (io_wr),
        .io_rd    (io_rd),
        .io_addr  (io_addr),
        .io_di    (io_di),
        .io_do    (io_do),
        .key_boot (key_boot),
        .spi_addr (spi_addr),
        .reboot   (reboot),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    // Behavioural model: unlock progress as a count of matched key bytes,
    // busy as a countdown of remaining busy cycles.
    int          m_unlock;
    int          m_busy;
    int          m_hold;
    logic [23:0] m_areg;
    logic [23:0] m_spi;
    logic        m_rb;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_unlock = 0;
        m_busy   = 0;
        m_hold   = 0;
        m_areg   = 24'h0;
        m_spi    = GOLDEN;
        m_rb     = 1'b0;
    endtask

    task automatic model_step(input logic wr, input logic [1:0] a,
                              input logic [7:0] d, input logic key);
        bit idle;
        int hp;
        bit kf;
        bit cf;
        idle = (m_busy == 0);
        hp = m_hold;
        m_hold = key ? ((m_hold < HOLD) ? m_hold + 1 : HOLD) : 0;
        kf = key && idle && (hp < HOLD) && (m_hold == HOLD);
        cf = 0;
        m_rb = 1'b0;
        if (m_busy > 0) m_busy--;
        if (idle && wr) begin
            if (a != 2'd3) begin
                m_areg[int'(a)*8 +: 8] = d;
            end else begin
                cf = (m_unlock == 2) && (d == 8'h01);
                if (m_unlock == 0 && d == 8'hA5) m_unlock = 1;
                else if (m_unlock == 1 && d == 8'h5A) m_unlock = 2;
                else m_unlock = 0;
            end
        end
        if (kf || cf) begin
            m_rb     = 1'b1;
            m_busy   = 1 + HOLDOFF;
            m_unlock = 0;
            m_spi    = kf ? GOLDEN : m_areg;
        end
    endtask

    function automatic logic [7:0] exp_do(input logic [1:0] a);
`ifdef MULTIBOOT_READBACK_EN
        logic [1:0] code;
        code = (m_busy > 0) ? 2'd3 : 2'(m_unlock);
        case (a)
            2'd0:    return m_areg[7:0];
            2'd1:    return m_areg[15:8];
            2'd2:    return m_areg[23:16];
            default: return {5'b0, (m_busy > 0), code};
        endcase
`else
        return (a == a) ? 8'hFF : 8'h00;
`endif
    endfunction

    task automatic check_all();
        chk("reboot", 32'(reboot), 32'(m_rb));
        chk("spi_addr", 32'(spi_addr), 32'(m_spi));
        chk("busy", 32'(busy), 32'(m_busy > 0));
        chk("io_do", 32'(io_do), 32'(exp_do(io_addr)));
        if (reboot === 1'b1) pulses++;
    endtask

    task automatic apply(input logic wr, input logic [1:0] a,
                         input logic [7:0] d, input logic key);
        reset    = 1'b0;
        io_wr    = wr;
        io_addr  = a;
        io_di    = d;
        key_boot = key;
        io_rd    = ~wr;
        @(posedge clock);
        model_step(wr, a, d, key);
        #1;
        check_all();
    endtask

    task automatic apply_reset(input logic key);
        reset    = 1'b1;
        io_wr    = 1'b0;
        key_boot = key;
        @(posedge clock);
        model_reset();
        #1;
        check_all();
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [7:0]  d;
        logic        key;
        logic        rb;
        logic [23:0] spi;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic wr, input logic [1:0] a,
                                input logic [7:0] d, input logic rb,
                                input logic [23:0] spi, input logic bsy);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.key = 1'b0;
        v.rb = rb; v.spi = spi; v.bsy = bsy;
        tbl.push_back(v);
    endfunction

    initial begin
        logic key_r;
        logic wr_r;
        logic [1:0] a_r;
        logic [7:0] d_r;
        int p0;

        model_reset();

        // Reset state
        repeat (3) apply_reset(1'b0);
        io_addr = 2'd3;
        #1;
        chk("rst_spi", 32'(spi_addr), 32'(GOLDEN));
        chk("rst_reboot", 32'(reboot), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef MULTIBOOT_READBACK_EN
        chk("rst_io_do", 32'(io_do), 32'h00);
`else
        chk("rst_io_do", 32'(io_do), 32'hFF);
`endif

        // Directed table: software fire, write during HOLDOFF, bad unlock
        add(1, 0, 8'h00, 0, 24'h0, 0);
        add(1, 1, 8'hC0, 0, 24'h0, 0);
        add(1, 2, 8'h0A, 0, 24'h0, 0);
        add(1, 3, 8'hA5, 0, 24'h0, 0);
        add(1, 3, 8'h5A, 0, 24'h0, 0);
        add(1, 3, 8'h01, 1, 24'h0AC000, 1);
        add(0, 0, 8'h00, 0, 24'h0AC000, 1);
        add(1, 2, 8'hFF, 0, 24'h0AC000, 1);
        for (int i = 0; i < 6; i++) add(0, 0, 8'h00, 0, 24'h0AC000, 1);
        add(0, 0, 8'h00, 0, 24'h0AC000, 0);
        add(1, 0, 8'h34, 0, 24'h0AC000, 0);
        add(1, 3, 8'hA5, 0, 24'h0AC000, 0);
        add(1, 3, 8'h33, 0, 24'h0AC000, 0);
        add(1, 3, 8'h5A, 0, 24'h0AC000, 0);
        add(1, 3, 8'h01, 0, 24'h0AC000, 0);
        add(1, 3, 8'hA5, 0, 24'h0AC000, 0);
        add(1, 3, 8'h5A, 0, 24'h0AC000, 0);
        add(1, 3, 8'h01, 1, 24'h0AC034, 1);
        for (int i = 0; i < 8; i++) add(0, 3, 8'h00, 0, 24'h0AC034, 1);
        add(0, 3, 8'h00, 0, 24'h0AC034, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].key);
            chk($sformatf("tbl%0d_reboot", i), 32'(reboot), 32'(tbl[i].rb));
            chk($sformatf("tbl%0d_spi", i), 32'(spi_addr), 32'(tbl[i].spi));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
        end

        // Key held one cycle short: no reboot
        p0 = pulses;
        repeat (HOLD - 1) apply(0, 3, 8'h00, 1'b1);
        apply(0, 3, 8'h00, 1'b0);
        chk("key_short_pulses", 32'(pulses - p0), 32'd0);

        // Key held to terminal count and beyond: exactly one golden reboot
        p0 = pulses;
        repeat (HOLD - 1) apply(0, 3, 8'h00, 1'b1);
        apply(0, 3, 8'h00, 1'b1);
        chk("key_fire_reboot", 32'(reboot), 32'd1);
        chk("key_fire_spi", 32'(spi_addr), 32'(GOLDEN));
        repeat (40) apply(0, 3, 8'h00, 1'b1);
        chk("key_hold_pulses", 32'(pulses - p0), 32'd1);
        repeat (10) apply(0, 3, 8'h00, 1'b0);

        // Key terminal count coincides with the CTRL trigger while ARMED
        p0 = pulses;
        repeat (HOLD - 3) apply(0, 0, 8'h00, 1'b1);
        apply(1, 3, 8'hA5, 1'b1);
        apply(1, 3, 8'h5A, 1'b1);
        apply(1, 3, 8'h01, 1'b1);
        chk("both_reboot", 32'(reboot), 32'd1);
        chk("both_spi", 32'(spi_addr), 32'(GOLDEN));
        repeat (12) apply(0, 0, 8'h00, 1'b1);
        chk("both_pulses", 32'(pulses - p0), 32'd1);
        repeat (12) apply(0, 0, 8'h00, 1'b0);

        // Reset in the middle of HOLDOFF
        apply(1, 3, 8'hA5, 1'b0);
        apply(1, 3, 8'h5A, 1'b0);
        apply(1, 3, 8'h01, 1'b0);
        chk("pre_rst_spi", 32'(spi_addr), 32'h0AC034);
        repeat (3) apply(0, 0, 8'h00, 1'b0);
        apply(1, 2, 8'hFF, 1'b0);
        chk("holdoff_wr_spi", 32'(spi_addr), 32'h0AC034);
        apply_reset(1'b0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_spi", 32'(spi_addr), 32'(GOLDEN));
        chk("mid_rst_reboot", 32'(reboot), 32'd0);
        apply(0, 0, 8'h00, 1'b0);
        apply(0, 1, 8'h00, 1'b0);
        apply(0, 2, 8'h00, 1'b0);
`ifdef MULTIBOOT_READBACK_EN
        chk("mid_rst_addr_h", 32'(io_do), 32'h00);
`endif
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Randomized traffic against the model
        key_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 699) == 0) begin
                apply_reset(key_r);
                continue;
            end
            if ($urandom_range(0, 29) == 0) key_r = ~key_r;
            wr_r = ($urandom_range(0, 2) == 0);
            a_r  = 2'($urandom_range(0, 3));
            if (wr_r && $urandom_range(0, 1) == 0) a_r = 2'd3;
            case ($urandom_range(0, 3))
                0:       d_r = 8'hA5;
                1:       d_r = 8'h5A;
                2:       d_r = 8'h01;
                default: d_r = 8'($urandom);
            endcase
            apply(wr_r, a_r, d_r, key_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
